// File: rtl/tone_sched_if.sv
// Bundle of requester-side signals shared between the speaker scheduler and its clients.
// The requesters drive req/code/dur; the scheduler returns handshakes and the tone.
interface tone_sched_if #(
    parameter int N_REQ = 3,
    parameter int DUR_W = 6
);
    logic [N_REQ-1:0]       req;
    logic [3*N_REQ-1:0]     code;
    logic [DUR_W*N_REQ-1:0] dur;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [2:0]             cur_code;
    logic                   speaker;

    modport master (
        output req, code, dur,
        input  gnt, done, busy, cur_code, speaker
    );

    modport slave (
        input  req, code, dur,
        output gnt, done, busy, cur_code, speaker
    );
endinterface

// File: rtl/tone_sched.sv
// Round-robin speaker scheduler: grants one requester at a time, plays its square-wave
// tone for the requested number of cycles, then inserts a fixed silent gap.
module tone_sched #(
    parameter int N_REQ   = 3,
    parameter int DUR_W   = 6,
    parameter int GAP_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    tone_sched_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = $clog2(GAP_CYC + 2);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    ptr, ptr_n, win, idx, win_q, win_q_n;
    logic             found;
    logic [2:0]       sel_code, code_q, code_q_n;
    logic [DUR_W-1:0] sel_dur, rem, rem_n;
    logic [GW-1:0]    gap_left, gap_left_n;
    logic [2:0]       cnt, cnt_n;
    logic             phase, phase_n;
    logic [N_REQ-1:0] gnt_q, gnt_n, done_q, done_n;
    logic [2:0]       cur_code_q, cur_code_n;
    logic             busy_q, busy_n, speaker_q, speaker_n;

    // Counter value past which the phase flips; half-period is this plus two cycles.
    function automatic logic [2:0] thr_of(input logic [2:0] c);
        return (c == 3'd5) ? 3'd1 : c + 3'd2;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Rotating search starting one past the last winner.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (idx == PW'(N_REQ - 1)) ? '0 : idx + PW'(1);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_code = '0;
        sel_dur  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == PW'(i)) begin
                sel_code = bus.code[3*i +: 3];
                sel_dur  = bus.dur[DUR_W*i +: DUR_W];
            end
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through the case infers a latch.
        state_n    = state;
        ptr_n      = ptr;
        win_q_n    = win_q;
        code_q_n   = code_q;
        rem_n      = rem;
        gap_left_n = gap_left;
        cnt_n      = cnt;
        phase_n    = phase;
        cur_code_n = cur_code_q;
        gnt_n      = '0;
        done_n     = '0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    ptr_n    = win;
                    win_q_n  = win;
                    code_q_n = sel_code;
                    cnt_n    = '0;
                    phase_n  = 1'b0;
                    gnt_n    = onehot(win);
                    if (sel_dur != '0) begin
                        state_n    = PLAY;
                        rem_n      = sel_dur;
                        cur_code_n = sel_code;
                    end else begin
                        // Extra GAP slot stands in for the skipped tone so done lands one cycle later.
                        state_n    = GAP;
                        gap_left_n = GW'(GAP_CYC + 1);
                        cur_code_n = '0;
                    end
                end
            end
            PLAY: begin
                rem_n = rem - DUR_W'(1);
                if (code_q[2:1] == 2'b11) begin
                    cnt_n = '0;
                end else if (cnt > thr_of(code_q)) begin
                    phase_n = ~phase;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
                if (rem == DUR_W'(1)) begin
                    state_n    = GAP;
                    gap_left_n = GW'(GAP_CYC);
                    done_n     = onehot(win_q);
                    cur_code_n = '0;
                end
            end
            GAP: begin
                if (gap_left == GW'(GAP_CYC + 1)) done_n = onehot(win_q);
                if (gap_left == GW'(1)) state_n = IDLE;
                else                    gap_left_n = gap_left - GW'(1);
            end
            default: state_n = IDLE;
        endcase

        busy_n    = (state_n != IDLE);
        speaker_n = (state_n == PLAY) && phase_n;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= PW'(N_REQ - 1);
            win_q      <= '0;
            code_q     <= '0;
            rem        <= '0;
            gap_left   <= '0;
            cnt        <= '0;
            phase      <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            cur_code_q <= '0;
            busy_q     <= 1'b0;
            speaker_q  <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            win_q      <= win_q_n;
            code_q     <= code_q_n;
            rem        <= rem_n;
            gap_left   <= gap_left_n;
            cnt        <= cnt_n;
            phase      <= phase_n;
            gnt_q      <= gnt_n;
            done_q     <= done_n;
            cur_code_q <= cur_code_n;
            busy_q     <= busy_n;
            speaker_q  <= speaker_n;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;
    assign bus.cur_code = cur_code_q;
    assign bus.speaker  = speaker_q;
endmodule

// File: tb/tb_tone_sched.sv
// Directed bench for tone_sched: a timeline model of each tone checks every output on every
// cycle, while hand-computed patterns pin down the scenarios the model must agree with.
module tb_tone_sched;
    localparam int N_REQ   = 3;
    localparam int DUR_W   = 6;
    localparam int GAP_CYC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    tone_sched_if #(.N_REQ(N_REQ), .DUR_W(DUR_W)) bus ();

    tone_sched #(.N_REQ(N_REQ), .DUR_W(DUR_W), .GAP_CYC(GAP_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: one tone at a time, described by its grant offset m_t and its length.
    int m_ptr = N_REQ - 1;
    bit m_act = 1'b0;
    int m_win, m_code, m_dur, m_t, m_len, m_i;
    logic [N_REQ-1:0] e_gnt, e_done;
    logic             e_busy, e_spk;
    logic [2:0]       e_cc;

    function automatic int half_period(input int c);
        return ((c == 5) ? 1 : c + 2) + 2;
    endfunction

    initial begin : model_and_compare
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_ptr = N_REQ - 1;
                m_act = 1'b0;
            end else if (m_act) begin
                m_t++;
                if (m_t == m_len) m_act = 1'b0;
            end else begin
                for (int k = 1; k <= N_REQ && !m_act; k++) begin
                    m_i = (m_ptr + k) % N_REQ;
                    if (bus.req[m_i]) begin
                        m_act  = 1'b1;
                        m_win  = m_i;
                        m_ptr  = m_i;
                        m_code = int'(bus.code[3*m_i +: 3]);
                        m_dur  = int'(bus.dur[DUR_W*m_i +: DUR_W]);
                        m_t    = 0;
                        m_len  = ((m_dur == 0) ? 1 : m_dur) + GAP_CYC;
                    end
                end
            end

            @(negedge clk);
            if (!rst) begin
                e_gnt = '0; e_done = '0; e_busy = 1'b0; e_spk = 1'b0; e_cc = '0;
                if (m_act) begin
                    e_busy = 1'b1;
                    if (m_t == 0) e_gnt[m_win] = 1'b1;
                    if (m_t == ((m_dur == 0) ? 1 : m_dur)) e_done[m_win] = 1'b1;
                    if (m_dur != 0 && m_t < m_dur) begin
                        e_cc = 3'(m_code);
                        if (m_code < 6) e_spk = ((m_t / half_period(m_code)) % 2) == 1;
                    end
                end
                check("cyc_gnt",      32'(bus.gnt),      32'(e_gnt));
                check("cyc_done",     32'(bus.done),     32'(e_done));
                check("cyc_busy",     32'(bus.busy),     32'(e_busy));
                check("cyc_cur_code", 32'(bus.cur_code), 32'(e_cc));
                check("cyc_speaker",  32'(bus.speaker),  32'(e_spk));
            end
        end
    end

    task automatic set_req(input int i, input int c, input int d);
        bus.code[3*i +: 3]         = 3'(c);
        bus.dur[DUR_W*i +: DUR_W]  = DUR_W'(d);
        bus.req[i]                 = 1'b1;
    endtask

    task automatic wait_gnt(output logic [N_REQ-1:0] g, output bit dn);
        g  = '0;
        dn = 1'b0;
        for (int n = 0; n < 100 && g == '0; n++) begin
            @(negedge clk);
            if (bus.done != '0) dn = 1'b1;
            g = bus.gnt;
        end
        check("gnt_seen", 32'(g != '0), 32'd1);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && bus.busy; n++) @(negedge clk);
        check("idle_reached", 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [N_REQ-1:0] g;
    bit               dn;
    logic [15:0]      pat16;
    logic [11:0]      pat12;
    int               bc, off, prev;
    bit               spk, cc_ok, gs;
    logic [N_REQ-1:0] dd;
    int               rr_order [5] = '{0, 1, 2, 0, 1};

    initial begin
        bus.req  = '0;
        bus.code = '0;
        bus.dur  = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({bus.gnt, bus.done, bus.busy, bus.cur_code, bus.speaker}), 32'd0);
        rst = 1'b0;

        // Single tone, code 0, 16 cycles: half-period of 4.
        @(negedge clk);
        set_req(0, 0, 16);
        wait_gnt(g, dn);
        bus.req[0] = 1'b0;
        check("s1_gnt", 32'(g), 32'(3'b001));
        pat16 = {15'd0, bus.speaker};
        for (int k = 2; k <= 16; k++) begin
            @(negedge clk);
            if (k == 2) check("s1_gnt_one_cycle", 32'(bus.gnt), 32'd0);
            pat16 = {pat16[14:0], bus.speaker};
        end
        check("s1_speaker", 32'(pat16), 32'h0F0F);
        @(negedge clk);
        check("s1_done", 32'(bus.done), 32'(3'b001));
        @(negedge clk);
        check("s1_busy_gap2", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("s1_busy_after", 32'(bus.busy), 32'd0);

        // Round robin from a fresh pointer, all three held.
        pulse_reset();
        set_req(0, 1, 4);
        set_req(1, 2, 4);
        set_req(2, 3, 4);
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(g, dn);
            if (n == 4) bus.req = '0;
            check("rr_order", 32'(g), 32'(1 << rr_order[n]));
            if (n > 0) check("rr_spacing", 32'(cyc - prev), 32'd7);
            prev = cyc;
        end
        wait_idle();

        // Zero duration on requester 1.
        set_req(1, 2, 0);
        wait_gnt(g, dn);
        bus.req[1] = 1'b0;
        check("z_gnt", 32'(g), 32'(3'b010));
        check("z_no_done_at_gnt", 32'(bus.done), 32'd0);
        bc  = bus.busy ? 1 : 0;
        spk = bus.speaker;
        @(negedge clk);
        check("z_done", 32'(bus.done), 32'(3'b010));
        for (int n = 0; n < 20 && bus.busy; n++) begin
            bc++;
            spk |= bus.speaker;
            @(negedge clk);
        end
        check("z_busy_len", 32'(bc), 32'(1 + GAP_CYC));
        check("z_speaker", 32'(spk), 32'd0);

        // Silent code on requester 2.
        set_req(2, 6, 10);
        wait_gnt(g, dn);
        bus.req[2] = 1'b0;
        check("sil_gnt", 32'(g), 32'(3'b100));
        spk = bus.speaker;
        off = 0;
        dd  = '0;
        for (int n = 0; n < 40 && dd == '0; n++) begin
            @(negedge clk);
            off++;
            spk |= bus.speaker;
            dd = bus.done;
        end
        check("sil_done_offset", 32'(off), 32'd10);
        check("sil_done", 32'(dd), 32'(3'b100));
        check("sil_speaker", 32'(spk), 32'd0);
        wait_idle();

        // Loss tone; inputs change right after grant and must not matter.
        set_req(0, 5, 12);
        wait_gnt(g, dn);
        bus.req[0]         = 1'b0;
        bus.code[2:0]      = 3'd0;
        bus.dur[DUR_W-1:0] = DUR_W'(1);
        check("loss_gnt", 32'(g), 32'(3'b001));
        pat12 = {11'd0, bus.speaker};
        cc_ok = (bus.cur_code == 3'd5);
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            pat12 = {pat12[10:0], bus.speaker};
            cc_ok &= (bus.cur_code == 3'd5);
        end
        check("loss_speaker", 32'(pat12), 32'(12'b000111000111));
        check("loss_cur_code", 32'(cc_ok), 32'd1);
        wait_idle();

        // Reset in PLAY cycle 3, then a fresh grant must go to requester 0.
        set_req(1, 0, 8);
        wait_gnt(g, dn);
        check("rst_first_gnt", 32'(g), 32'(3'b010));
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", 32'({bus.gnt, bus.done, bus.busy, bus.cur_code, bus.speaker}), 32'd0);
        set_req(0, 1, 3);
        set_req(2, 4, 3);
        @(negedge clk);
        rst = 1'b0;
        wait_gnt(g, dn);
        check("rst_next_gnt", 32'(g), 32'(3'b001));
        check("rst_no_done", 32'(dn), 32'd0);

        // Requester 2 withdraws while the block is busy.
        bus.req = 3'b100;
        repeat (2) @(negedge clk);
        bus.req[2] = 1'b0;
        gs = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            gs |= (bus.gnt != '0);
        end
        check("withdraw_no_gnt", 32'(gs), 32'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tone_sched.md
# tone_sched

Speaker scheduler for the memory-game sound datapath. It shares the single speaker output among up to N_REQ requesters, for example the sequence-playback FSM, the key-echo logic and the win/loss annunciator. Requests are granted round-robin, the selected tone is generated for a requested number of cycles, and a fixed silent gap is inserted between tones. Each requester gets a one-cycle grant acknowledge and a one-cycle completion pulse.

## Interface
- N_REQ, 3, number of requesters (2..8)
- DUR_W, 6, width of each duration field
- GAP_CYC, 2, silent cycles after every tone (≥1)
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high; clears all state
- req  in  N_REQ  level request per requester; held until granted
- code_i  in  3*N_REQ  tone code of requester i at bits [3i+2:3i]: 0..3 colour tones, 4 win, 5 loss, 6/7 silent
- dur_i  in  DUR_W*N_REQ  tone length in clock cycles of requester i at bits [DUR_W*i+DUR_W-1:DUR_W*i]
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted, code/dur captured
- done  out  N_REQ  one-hot, one-cycle pulse: tone of that requester finished
- busy  out  1  high from grant cycle through the last GAP cycle
- cur_code  out  3  code being played, 0 when idle
- speaker  out  1  square-wave tone output

## Operation
- States: IDLE, PLAY, GAP. Reset: state IDLE, all outputs 0, rr pointer = N_REQ-1, tone counter 0, phase 0.
- Arbitration happens in IDLE only.
  - Search req from index ptr+1 cyclically; the first set bit wins.
  - ptr ← winner; gnt[winner] pulses; code and dur are latched; cur_code ← code; tone counter and phase ← 0.
- Grant with dur≠0 goes to PLAY with rem ← dur.
- Grant with dur = 0 skips PLAY: go directly to GAP and pulse done in the next cycle. Speaker stays 0.
- PLAY runs for exactly dur cycles, numbered 1..dur.
  - Each cycle rem decrements.
  - In the cycle with rem = 1, next state is GAP and done[winner] pulses in the first GAP cycle.
- Tone generation in PLAY:
  - Threshold per code: 0→2, 1→3, 2→4, 3→5, 4→6, 5→1.
  - Each cycle: if counter > thr, then phase ← ~phase and counter ← 0; otherwise counter ← counter+1 (3-bit).
  - speaker = phase while in PLAY. Half-period is thr+2 cycles.
  - Codes 6/7: counter held 0, speaker 0, duration still counts normally.
- speaker is forced 0 in IDLE and GAP. Phase resets to 0 on every grant.
- GAP lasts GAP_CYC cycles with speaker 0 and busy 1. cur_code clears to 0 on entry to GAP. Then the block returns to IDLE.
- A requester still holding req after its done pulse is a new request and competes in IDLE normally.
- Dropping req before gnt withdraws the request. No grant is issued, and no error is flagged.
- A change to code_i/dur_i after grant has no effect on the tone in progress.
- Asynchronous reset mid-PLAY or mid-GAP: the block goes to IDLE immediately, speaker, busy, gnt and done go to 0, and no done pulse is emitted for the aborted tone.

## Timing
- Latency from req high in IDLE (sampled at edge E) to the gnt pulse: gnt is high in the cycle following E.
- Minimum spacing between consecutive grants is dur + GAP_CYC + 1 cycles (IDLE lasts one cycle).
- The done pulse falls in the first GAP cycle and never coincides with a gnt pulse.
- All outputs are registered. No combinational path from req to gnt.

## Test plan
- Single tone, code 0:
  - Stimulus: req[0]=1, code 0, dur 16.
  - Required: gnt[0] one cycle; speaker 0 in PLAY cycles 1-4, 1 in cycles 5-8, 0 in cycles 9-12, 1 in cycles 13-16; done[0] in the next cycle; busy low after 2 GAP cycles.
- Round robin:
  - Stimulus: req=3'b111 held continuously, dur 4 each.
  - Required: grant order 0,1,2,0,1,…; each grant spaced 4+2+1 = 7 cycles apart.
- Zero duration:
  - Stimulus: req[1]=1 with dur 0.
  - Required: gnt[1], then done[1] one cycle later; speaker never 1; busy high for exactly 1+GAP_CYC cycles.
- Silent code:
  - Stimulus: code 6, dur 10.
  - Required: speaker 0 throughout; done after exactly 10 PLAY cycles.
- Loss tone:
  - Stimulus: code 5, dur 12.
  - Required: speaker toggles every 3 cycles (pattern 000111000111); cur_code = 5 during PLAY.
- Reset and withdrawal:
  - Stimulus: reset pulsed at PLAY cycle 3.
  - Required: all outputs 0 at once, no done pulse, next grant goes to requester 0.
  - Stimulus: req[2] raised, then dropped while busy.
  - Required: no gnt[2].
